ro_meas_ctrl: RTL

RO_MEAS_CTRL -- requirements
Module: ro_meas_ctrl

---
 rtl/ro_meas_pkg.sv | 21 ++
 rtl/ro_meas_ctrl_if.sv | 27 ++
 rtl/ro_edge_sync.sv | 26 ++
 rtl/ro_meas_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared FSM state encoding and default sizing for the ring-oscillator
// measurement controller.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam int N_RO_DEF       = 8;
    localparam int CNT_W_DEF      = 20;
    localparam int GATE_W_DEF     = 16;
    localparam int SETTLE_CYC_DEF = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_meas_ctrl_if.sv
// Measurement request/result bundle between a host sequencer and ro_meas_ctrl.
interface ro_meas_ctrl_if
    import ro_meas_pkg::*;
#(
    parameter int N_RO   = N_RO_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
);
    logic                    start;
    logic                    abort;
    logic [$clog2(N_RO)-1:0] ro_sel;
    logic [GATE_W-1:0]       gate_len;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        count;
    logic                    overflow;

    modport master (
        output start, abort, ro_sel, gate_len,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, abort, ro_sel, gate_len,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for an asynchronous oscillator output, followed by a
// history flop; rise_o pulses for one clk cycle per synchronized rising edge.
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);
    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~hist_q;
endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator frequency measurement: enable one RO, let it settle, then
// count its rising edges over a programmable gate window.
//   state    | meaning
//   S_IDLE   | waiting for start, results held
//   S_SETTLE | selected RO enabled, SETTLE_CYC cycles before counting
//   S_COUNT  | counting synchronized rising edges for gate_len cycles
//   S_DONE   | one-cycle result-valid pulse
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int N_RO       = N_RO_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int GATE_W     = GATE_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    ro_meas_ctrl_if.slave    bus,
    input  logic [N_RO-1:0]  ro_y,
    output logic [N_RO-1:0]  ro_en
);
    localparam int SEL_W = $clog2(N_RO);
    localparam int TMR_W = max_int(GATE_W, $clog2(SETTLE_CYC + 1));

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               ro_mux;
    logic               ro_rise;

    // Single synchronizer shared by all oscillators, fed through a plain mux.
    assign ro_mux = ro_y[sel_q];

    ro_edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ro_mux),
        .rise_o  (ro_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            gate_q  <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gate_q  <= gate_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gate_d  = gate_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    sel_d   = bus.ro_sel;
                    gate_d  = bus.gate_len;
                    tmr_d   = TMR_W'(SETTLE_CYC - 1);
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (tmr_q == '0) begin
                    if (gate_q != '0) begin
                        tmr_d   = TMR_W'(gate_q) - 1'b1;
                        state_d = S_COUNT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_COUNT: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (ro_rise) begin
                        if (cnt_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
                        else                        cnt_d = cnt_q + 1'b1;
                    end
                    if (tmr_q == '0) state_d = S_DONE;
                    else             tmr_d   = tmr_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.count    = cnt_q;
    assign bus.overflow = ovf_q;
    assign ro_en        = (state_q == S_SETTLE || state_q == S_COUNT)
                        ? (N_RO'(1) << sel_q) : '0;
endmodule
